// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// Drives PCin for a PC register that loads every edge; holds are realised by
// feeding PCout back. Sequences increment, stall, branch/jump redirect with a
// multi-cycle IF flush, and halt/resume. Keeps saturating performance counters.
// Optional misaligned-target trap enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      PCout,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             Halt,
  input  logic             Resume,
  output logic [31:0]      PCin,
  output logic             PCWrite,
  output logic             IF_Flush,
  output logic [2:0]       SeqState,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] Redirects,
  output logic             AlignErr
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_STALL  = 3'd1,
    S_FLUSH  = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirects_q, redirects_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic             align_err_q, align_err_d;
`endif

  logic [31:0] pc_inc;
  logic        take_redir;
  logic [31:0] redir_tgt;

  assign pc_inc = PCout + 32'(PC_STEP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Next-PC selection, next-state and counter updates.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    stall_cycles_d = stall_cycles_q;
    redirects_d    = redirects_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    align_err_d    = align_err_q;
`endif
    PCin       = pc_inc;
    PCWrite    = 1'b1;
    IF_Flush   = 1'b0;
    take_redir = 1'b0;
    redir_tgt  = BranchTarget;

    unique case (state_q)
      S_RUN, S_STALL: begin
        // Branch is the older instruction, so it outranks the jump.
        if (BranchTaken) begin
          take_redir = 1'b1;
          redir_tgt  = BranchTarget;
        end else if (Jump) begin
          take_redir = 1'b1;
          redir_tgt  = JumpTarget;
        end else if (Halt) begin
          PCin    = PCout;
          PCWrite = 1'b0;
          state_d = S_HALTED;
        end else if (Stall) begin
          PCin           = PCout;
          PCWrite        = 1'b0;
          state_d        = S_STALL;
          stall_cycles_d = sat_inc(stall_cycles_q);
        end else begin
          state_d = S_RUN;
        end

        if (take_redir) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
          if (redir_tgt[1:0] != 2'b00) begin
            PCin        = PCout;
            PCWrite     = 1'b0;
            IF_Flush    = 1'b1;
            align_err_d = 1'b1;
            state_d     = S_ERROR;
          end else
`endif
          begin
            PCin        = redir_tgt;
            IF_Flush    = 1'b1;
            redirects_d = sat_inc(redirects_q);
            flush_cnt_d = 4'(FLUSH_CYCLES - 1);
            state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
          end
        end
      end

      S_FLUSH: begin
        // Requests here come from squashed instructions and are ignored.
        IF_Flush    = 1'b1;
        flush_cnt_d = (flush_cnt_q == '0) ? '0 : flush_cnt_q - 4'd1;
        state_d     = (flush_cnt_q <= 4'd1) ? S_RUN : S_FLUSH;
      end

      S_HALTED: begin
        if (Resume) begin
          state_d = S_RUN;
        end else begin
          PCin    = PCout;
          PCWrite = 1'b0;
        end
      end

      default: begin
        PCin    = PCout;
        PCWrite = 1'b0;
      end
    endcase

    if (Rst) begin
      PCin     = '0;
      PCWrite  = 1'b0;
      IF_Flush = 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= S_RUN;
      flush_cnt_q    <= '0;
      stall_cycles_q <= '0;
      redirects_q    <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      redirects_q    <= redirects_d;
    end
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  // Sticky misaligned-target flag.
  always_ff @(posedge Clk) begin
    if (Rst) align_err_q <= 1'b0;
    else     align_err_q <= align_err_d;
  end
  assign AlignErr = align_err_q;
`else
  assign AlignErr = 1'b0;
`endif

  assign SeqState    = state_q;
  assign StallCycles = stall_cycles_q;
  assign Redirects   = redirects_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes hand-computed expectations,
// a monitor pops and compares once per cycle away from the clock edge.
module tb_pc_sequencer;

  logic        Clk;
  logic        Rst;
  logic [31:0] PCout;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Halt;
  logic        Resume;
  logic [31:0] PCin;
  logic        PCWrite;
  logic        IF_Flush;
  logic [2:0]  SeqState;
  logic [15:0] StallCycles;
  logic [15:0] Redirects;
  logic        AlignErr;

  pc_sequencer #(
    .PC_STEP      (4),
    .FLUSH_CYCLES (3),
    .CNT_W        (16)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PCout        (PCout),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Halt         (Halt),
    .Resume       (Resume),
    .PCin         (PCin),
    .PCWrite      (PCWrite),
    .IF_Flush     (IF_Flush),
    .SeqState     (SeqState),
    .StallCycles  (StallCycles),
    .Redirects    (Redirects),
    .AlignErr     (AlignErr)
  );

  typedef struct {
    logic [31:0] pcin;
    logic        w;
    logic        f;
    logic [2:0]  st;
    logic [15:0] sc;
    logic [15:0] rd;
    logic        ae;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of inputs at the falling edge and queue its expectation.
  task automatic vec(input logic rst, input logic [31:0] pco,
                     input logic stl, input logic bt, input logic [31:0] btg,
                     input logic jp, input logic [31:0] jtg,
                     input logic hl, input logic rs,
                     input logic [31:0] e_pc, input logic e_w, input logic e_f,
                     input logic [2:0] e_st, input logic [15:0] e_sc,
                     input logic [15:0] e_rd, input logic e_ae, input string nm);
    exp_t e;
    @(negedge Clk);
    Rst = rst; PCout = pco; Stall = stl; BranchTaken = bt; BranchTarget = btg;
    Jump = jp; JumpTarget = jtg; Halt = hl; Resume = rs;
    e.pcin = e_pc; e.w = e_w; e.f = e_f; e.st = e_st;
    e.sc = e_sc; e.rd = e_rd; e.ae = e_ae; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: compares outputs 2 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({PCin, PCWrite, IF_Flush, SeqState, StallCycles, Redirects, AlignErr} !==
            {e.pcin, e.w, e.f, e.st, e.sc, e.rd, e.ae}) begin
          n_fail++;
          $display("FAIL %s: got pcin=%h w=%b f=%b st=%0d sc=%h rd=%h ae=%b, expected pcin=%h w=%b f=%b st=%0d sc=%h rd=%h ae=%b",
                   e.name, PCin, PCWrite, IF_Flush, SeqState, StallCycles, Redirects, AlignErr,
                   e.pcin, e.w, e.f, e.st, e.sc, e.rd, e.ae);
        end
      end
    end
  end

  initial begin
    Rst = 1'b1; PCout = '0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    Jump = 1'b0; JumpTarget = '0; Halt = 1'b0; Resume = 1'b0;

    // reset and increment
    vec(1, 32'h0, 0,0,0, 0,0, 0,0,  32'h0,  0,1, 0, 16'd0, 16'd0, 0, "rst0");
    vec(1, 32'h0, 0,0,0, 0,0, 0,0,  32'h0,  0,1, 0, 16'd0, 16'd0, 0, "rst1");
    vec(0, 32'h0, 0,0,0, 0,0, 0,0,  32'h4,  1,0, 0, 16'd0, 16'd0, 0, "inc0");
    vec(0, 32'h4, 0,0,0, 0,0, 0,0,  32'h8,  1,0, 0, 16'd0, 16'd0, 0, "inc1");
    vec(0, 32'h8, 0,0,0, 0,0, 0,0,  32'hC,  1,0, 0, 16'd0, 16'd0, 0, "inc2");

    // stall for 3 cycles at 0x10
    vec(0, 32'h10, 1,0,0, 0,0, 0,0, 32'h10, 0,0, 0, 16'd0, 16'd0, 0, "st_enter");
    vec(0, 32'h10, 1,0,0, 0,0, 0,0, 32'h10, 0,0, 1, 16'd1, 16'd0, 0, "st_hold1");
    vec(0, 32'h10, 1,0,0, 0,0, 0,0, 32'h10, 0,0, 1, 16'd2, 16'd0, 0, "st_hold2");
    vec(0, 32'h10, 0,0,0, 0,0, 0,0, 32'h14, 1,0, 1, 16'd3, 16'd0, 0, "st_rel");
    vec(0, 32'h14, 0,0,0, 0,0, 0,0, 32'h18, 1,0, 0, 16'd3, 16'd0, 0, "st_run");

    // branch beats jump and stall while stalled; flush ignores requests
    vec(0, 32'h18, 1,0,0, 0,0, 0,0, 32'h18, 0,0, 0, 16'd3, 16'd0, 0, "br_stall");
    vec(0, 32'h18, 1,1,32'h40, 1,32'h80, 0,0, 32'h40, 1,1, 1, 16'd4, 16'd0, 0, "br_take");
    vec(0, 32'h40, 1,0,0, 1,32'h80, 1,0, 32'h44, 1,1, 2, 16'd4, 16'd1, 0, "fl1");
    vec(0, 32'h44, 0,0,0, 1,32'h80, 0,0, 32'h48, 1,1, 2, 16'd4, 16'd1, 0, "fl2");
    vec(0, 32'h48, 0,0,0, 0,0, 0,0, 32'h4C, 1,0, 0, 16'd4, 16'd1, 0, "fl_done");

    // halt, hold 5 cycles ignoring requests, resume
    vec(0, 32'h20, 0,0,0, 0,0, 1,0, 32'h20, 0,0, 0, 16'd4, 16'd1, 0, "halt_req");
    for (int i = 0; i < 4; i++)
      vec(0, 32'h20, 1,1,32'h40, 1,32'h80, 0,0, 32'h20, 0,0, 3, 16'd4, 16'd1, 0, "halted");
    vec(0, 32'h20, 0,0,0, 0,0, 0,1, 32'h24, 1,0, 3, 16'd4, 16'd1, 0, "resume");
    vec(0, 32'h24, 0,0,0, 0,0, 0,0, 32'h28, 1,0, 0, 16'd4, 16'd1, 0, "res_run");
    vec(0, 32'h28, 1,0,0, 0,0, 1,0, 32'h28, 0,0, 0, 16'd4, 16'd1, 0, "halt_stall");
    vec(0, 32'h28, 0,0,0, 0,0, 1,1, 32'h2C, 1,0, 3, 16'd4, 16'd1, 0, "halt_res_both");
    vec(0, 32'h2C, 0,0,0, 0,0, 0,0, 32'h30, 1,0, 0, 16'd4, 16'd1, 0, "both_run");

    // 32-bit wrap
    vec(0, 32'hFFFF_FFFC, 0,0,0, 0,0, 0,0, 32'h0, 1,0, 0, 16'd4, 16'd1, 0, "wrap");

    // misaligned jump target, then reset in the middle of the resulting state
`ifdef PC_SEQ_ALIGN_CHECK_EN
    vec(0, 32'h100, 0,0,0, 1,32'h42, 0,0, 32'h100, 0,1, 0, 16'd4, 16'd1, 0, "jmp_42");
    vec(0, 32'h100, 0,0,0, 1,32'h80, 0,1, 32'h100, 0,0, 4, 16'd4, 16'd1, 1, "err_hold");
    vec(1, 32'h46, 0,0,0, 0,0, 0,0, 32'h0, 0,1, 4, 16'd4, 16'd1, 1, "rst_mid");
`else
    vec(0, 32'h100, 0,0,0, 1,32'h42, 0,0, 32'h42, 1,1, 0, 16'd4, 16'd1, 0, "jmp_42");
    vec(0, 32'h42, 0,0,0, 0,0, 0,0, 32'h46, 1,1, 2, 16'd4, 16'd2, 0, "jmp_42_fl");
    vec(1, 32'h46, 0,0,0, 0,0, 0,0, 32'h0, 0,1, 2, 16'd4, 16'd2, 0, "rst_mid");
`endif
    vec(0, 32'h0, 0,0,0, 0,0, 0,0, 32'h4, 1,0, 0, 16'd0, 16'd0, 0, "post_rst");

    // long stall to saturate StallCycles
    for (int i = 0; i < 65540; i++) begin
      @(negedge Clk);
      PCout = 32'h10; Stall = 1'b1;
    end
    vec(0, 32'h10, 1,0,0, 0,0, 0,0, 32'h10, 0,0, 1, 16'hFFFF, 16'd0, 0, "sat_hold");
    vec(0, 32'h10, 0,0,0, 0,0, 0,0, 32'h14, 1,0, 1, 16'hFFFF, 16'd0, 0, "sat_rel");
    vec(0, 32'h14, 0,0,0, 0,0, 0,0, 32'h18, 1,0, 0, 16'hFFFF, 16'd0, 0, "sat_run");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge Clk);
      #3;
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
